// File: rtl/tensor_ram_arbiter.sv
// Round-robin arbiter sharing one tensor_ram write port and one read port among several requesters,
// with optional burst locks, one-cycle read-return routing and out-of-range address trapping.
module tensor_ram_arbiter #(
    parameter int unsigned NUM_RD  = 2,
    parameter int unsigned NUM_WR  = 2,
    parameter int unsigned D_WIDTH = 32,
    parameter int unsigned DEPTH   = 96*96,
    parameter int unsigned AW      = $clog2(DEPTH)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_WR-1:0]         wr_req,
    input  logic [NUM_WR-1:0]         wr_lock,
    input  logic [NUM_WR*AW-1:0]      wr_addr,
    input  logic [NUM_WR*D_WIDTH-1:0] wr_data,
    output logic [NUM_WR-1:0]         wr_gnt,
    input  logic [NUM_RD-1:0]         rd_req,
    input  logic [NUM_RD-1:0]         rd_lock,
    input  logic [NUM_RD*AW-1:0]      rd_addr,
    output logic [NUM_RD-1:0]         rd_gnt,
    output logic [NUM_RD-1:0]         rd_valid,
    output logic [D_WIDTH-1:0]        rd_data,
    output logic                      ram_we,
    output logic [AW-1:0]             ram_addr_w,
    output logic [D_WIDTH-1:0]        ram_din,
    output logic [AW-1:0]             ram_addr_r,
    input  logic [D_WIDTH-1:0]        ram_dout,
    output logic                      err_oob
);

    localparam int unsigned WPW = (NUM_WR > 1) ? $clog2(NUM_WR) : 1;
    localparam int unsigned RPW = (NUM_RD > 1) ? $clog2(NUM_RD) : 1;
    localparam logic [AW:0] DEPTH_LIM = (AW+1)'(DEPTH);

    function automatic logic [WPW-1:0] wr_wrap(input int unsigned v);
        return WPW'(v % NUM_WR);
    endfunction

    function automatic logic [RPW-1:0] rd_wrap(input int unsigned v);
        return RPW'(v % NUM_RD);
    endfunction

    logic [WPW-1:0]     wr_ptr_q, wr_ptr_d, wr_own_q, wr_own_d, wr_idx;
    logic               wr_own_vld_q, wr_own_vld_d, wr_any, wr_oob;
    logic [AW-1:0]      wr_sel_addr;
    logic [D_WIDTH-1:0] wr_sel_data;

    logic [RPW-1:0]     rd_ptr_q, rd_ptr_d, rd_own_q, rd_own_d, rd_idx;
    logic               rd_own_vld_q, rd_own_vld_d, rd_any, rd_oob;
    logic [AW-1:0]      rd_sel_addr, ram_addr_r_q;
    logic [NUM_RD-1:0]  rd_valid_q;
    logic               oob_q, err_q;

    // Write arbitration: a live lock owner beats the round-robin search.
    always_comb begin
        wr_any = 1'b0;
        wr_idx = '0;
        if (wr_own_vld_q && wr_req[wr_own_q]) begin
            wr_any = 1'b1;
            wr_idx = wr_own_q;
        end else begin
            for (int unsigned i = 0; i < NUM_WR; i++) begin
                if (!wr_any && wr_req[wr_wrap(32'(wr_ptr_q) + i)]) begin
                    wr_any = 1'b1;
                    wr_idx = wr_wrap(32'(wr_ptr_q) + i);
                end
            end
        end
        wr_any = wr_any & rst_n;
    end

    always_comb begin
        rd_any = 1'b0;
        rd_idx = '0;
        if (rd_own_vld_q && rd_req[rd_own_q]) begin
            rd_any = 1'b1;
            rd_idx = rd_own_q;
        end else begin
            for (int unsigned i = 0; i < NUM_RD; i++) begin
                if (!rd_any && rd_req[rd_wrap(32'(rd_ptr_q) + i)]) begin
                    rd_any = 1'b1;
                    rd_idx = rd_wrap(32'(rd_ptr_q) + i);
                end
            end
        end
        rd_any = rd_any & rst_n;
    end

    always_comb begin
        wr_sel_addr = wr_addr[32'(wr_idx) * AW +: AW];
        wr_sel_data = wr_data[32'(wr_idx) * D_WIDTH +: D_WIDTH];
        rd_sel_addr = rd_addr[32'(rd_idx) * AW +: AW];
        wr_oob      = {1'b0, wr_sel_addr} >= DEPTH_LIM;
        rd_oob      = {1'b0, rd_sel_addr} >= DEPTH_LIM;

        wr_gnt      = wr_any ? (NUM_WR'(1) << wr_idx) : '0;
        rd_gnt      = rd_any ? (NUM_RD'(1) << rd_idx) : '0;
        ram_we      = wr_any & ~wr_oob;
        ram_addr_w  = wr_any ? wr_sel_addr : '0;
        ram_din     = wr_any ? wr_sel_data : '0;
        ram_addr_r  = rd_any ? rd_sel_addr : ram_addr_r_q;

        rd_valid    = rd_valid_q;
        rd_data     = (rst_n && !oob_q) ? ram_dout : '0;
        err_oob     = err_q;

        // Pointer always lands past the granted index, so a released owner yields its turn.
        wr_ptr_d     = wr_any ? wr_wrap(32'(wr_idx) + 1) : wr_ptr_q;
        wr_own_vld_d = wr_any & wr_lock[wr_idx];
        wr_own_d     = wr_idx;
        rd_ptr_d     = rd_any ? rd_wrap(32'(rd_idx) + 1) : rd_ptr_q;
        rd_own_vld_d = rd_any & rd_lock[rd_idx];
        rd_own_d     = rd_idx;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q     <= '0;
            wr_own_q     <= '0;
            wr_own_vld_q <= 1'b0;
            rd_ptr_q     <= '0;
            rd_own_q     <= '0;
            rd_own_vld_q <= 1'b0;
            ram_addr_r_q <= '0;
            rd_valid_q   <= '0;
            oob_q        <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            wr_own_q     <= wr_own_d;
            wr_own_vld_q <= wr_own_vld_d;
            rd_ptr_q     <= rd_ptr_d;
            rd_own_q     <= rd_own_d;
            rd_own_vld_q <= rd_own_vld_d;
            ram_addr_r_q <= ram_addr_r;
            rd_valid_q   <= rd_gnt;
            oob_q        <= rd_any & rd_oob;
            err_q        <= err_q | (wr_any & wr_oob) | (rd_any & rd_oob);
        end
    end

endmodule

// File: tb/tb_tensor_ram_arbiter.sv
// Self-checking bench for tensor_ram_arbiter: behavioural RAM plus a scoreboard of read returns.
module tb_tensor_ram_arbiter;

    localparam int unsigned DEPTH = 9216;
    localparam int unsigned AW    = 14;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_n;
    logic [1:0]    wr_req, wr_lock, wr_gnt;
    logic [2*AW-1:0] wr_addr;
    logic [63:0]   wr_data;
    logic [1:0]    rd_req, rd_lock, rd_gnt, rd_valid;
    logic [2*AW-1:0] rd_addr;
    logic [31:0]   rd_data, ram_din, ram_dout;
    logic          ram_we, err_oob;
    logic [AW-1:0] ram_addr_w, ram_addr_r;

    tensor_ram_arbiter #(
        .NUM_RD  (2),
        .NUM_WR  (2),
        .D_WIDTH (32),
        .DEPTH   (DEPTH)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .wr_req     (wr_req),
        .wr_lock    (wr_lock),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .wr_gnt     (wr_gnt),
        .rd_req     (rd_req),
        .rd_lock    (rd_lock),
        .rd_addr    (rd_addr),
        .rd_gnt     (rd_gnt),
        .rd_valid   (rd_valid),
        .rd_data    (rd_data),
        .ram_we     (ram_we),
        .ram_addr_w (ram_addr_w),
        .ram_din    (ram_din),
        .ram_addr_r (ram_addr_r),
        .ram_dout   (ram_dout),
        .err_oob    (err_oob)
    );

    // RAM with write-first forwarding; out-of-range reads return a garbage pattern.
    logic [31:0] mem [DEPTH];
    always @(posedge clk) begin
        if (ram_we) mem[ram_addr_w] <= ram_din;
        if (ram_we && ram_addr_w == ram_addr_r) ram_dout <= ram_din;
        else if (32'(ram_addr_r) < DEPTH) ram_dout <= mem[ram_addr_r];
        else ram_dout <= 32'hBAD0_0000 | 32'(ram_addr_r);
    end

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    endtask

    typedef struct packed {
        logic [1:0]  vld;
        logic [31:0] data;
    } rd_exp_t;

    rd_exp_t sb[$];
    rd_exp_t mon_e;

    always @(posedge clk) begin
        #3;
        if (sb.size() != 0) begin
            mon_e = sb.pop_front();
            check("rd_valid", 64'(rd_valid), 64'(mon_e.vld));
            check("rd_data", 64'(rd_data), 64'(mon_e.data));
        end else if (rd_valid != 2'b00) begin
            check("spurious rd_valid", 64'(rd_valid), 64'(0));
        end
    end

    // Called just after a negedge with inputs driven; checks grants and queues the read return.
    task automatic tick(input string tag, input logic [1:0] exp_wg, input logic [1:0] exp_rg,
                        input logic exp_we, input logic [31:0] exp_rd);
        #1;
        check({tag, " wr_gnt"}, 64'(wr_gnt), 64'(exp_wg));
        check({tag, " rd_gnt"}, 64'(rd_gnt), 64'(exp_rg));
        check({tag, " ram_we"}, 64'(ram_we), 64'(exp_we));
        if (exp_rg != 2'b00) sb.push_back('{vld: exp_rg, data: exp_rd});
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        wr_req  = 2'b00;
        wr_lock = 2'b00;
        rd_req  = 2'b00;
        rd_lock = 2'b00;
    endtask

    initial begin
        rst_n   = 1'b0;
        wr_req  = 2'b11;
        wr_lock = 2'b00;
        rd_req  = 2'b11;
        rd_lock = 2'b00;
        wr_addr = '0;
        wr_data = '0;
        rd_addr = '0;
        repeat (2) @(negedge clk);
        #1;
        check("reset wr_gnt", 64'(wr_gnt), 64'(0));
        check("reset rd_gnt", 64'(rd_gnt), 64'(0));
        check("reset ram_we", 64'(ram_we), 64'(0));
        check("reset rd_valid", 64'(rd_valid), 64'(0));
        check("reset err_oob", 64'(err_oob), 64'(0));
        @(negedge clk);
        idle_inputs();
        rst_n = 1'b1;
        @(negedge clk);

        // Round-robin writes; each writer changes data only after being granted.
        wr_addr = {14'd6, 14'd5};
        for (int k = 0; k < 4; k++) begin
            wr_req  = 2'b11;
            wr_data = {32'h6000_0000 + 32'(k >> 1), 32'h5000_0000 + 32'(k >> 1)};
            #1;
            check("rr ram_addr_w", 64'(ram_addr_w), (k % 2 == 0) ? 64'd5 : 64'd6);
            check("rr ram_din", 64'(ram_din),
                  (k % 2 == 0) ? 64'(32'h5000_0000 + 32'(k >> 1))
                               : 64'(32'h6000_0000 + 32'(k >> 1)));
            tick("rr", (k % 2 == 0) ? 2'b01 : 2'b10, 2'b00, 1'b1, 32'h0);
        end

        // Read back 5/6 while loading 10/11 for later tests.
        wr_req = 2'b01; wr_addr[0 +: AW] = 14'd10; wr_data[31:0] = 32'hDEAD_BEEF;
        rd_req = 2'b01; rd_addr[0 +: AW] = 14'd5;
        tick("rb0", 2'b01, 2'b01, 1'b1, 32'h5000_0001);
        wr_req = 2'b10; wr_addr[AW +: AW] = 14'd11; wr_data[63:32] = 32'h0102_0304;
        rd_req = 2'b10; rd_addr[AW +: AW] = 14'd6;
        tick("rb1", 2'b10, 2'b10, 1'b1, 32'h6000_0001);

        // Read return routing on back-to-back grants.
        idle_inputs();
        rd_req = 2'b01; rd_addr[0 +: AW] = 14'd10;
        tick("route0", 2'b00, 2'b01, 1'b0, 32'hDEAD_BEEF);
        rd_req = 2'b10; rd_addr[AW +: AW] = 14'd11;
        tick("route1", 2'b00, 2'b10, 1'b0, 32'h0102_0304);
        rd_req = 2'b00;
        #1;
        check("ram_addr_r hold", 64'(ram_addr_r), 64'd11);
        tick("idle", 2'b00, 2'b00, 1'b0, 32'h0);

        // Lock: move rd_ptr to 1, then reader 1 holds the port for 4 cycles.
        rd_req = 2'b01;
        tick("lock pre", 2'b00, 2'b01, 1'b0, 32'hDEAD_BEEF);
        for (int k = 0; k < 4; k++) begin
            rd_req  = 2'b11;
            rd_lock = 2'b10;
            tick("lock hold", 2'b00, 2'b10, 1'b0, 32'h0102_0304);
        end
        rd_req  = 2'b01;
        rd_lock = 2'b00;
        tick("lock release", 2'b00, 2'b01, 1'b0, 32'hDEAD_BEEF);

        // Same-cycle write and read of addr 100.
        wr_req = 2'b01; wr_addr[0 +: AW] = 14'd100; wr_data[31:0] = 32'hA5A5_A5A5;
        rd_req = 2'b01; rd_addr[0 +: AW] = 14'd100;
        tick("rdw", 2'b01, 2'b01, 1'b1, 32'hA5A5_A5A5);

        // Out-of-range write then read.
        idle_inputs();
        #1;
        check("err_oob before", 64'(err_oob), 64'(0));
        wr_req = 2'b10; wr_addr[AW +: AW] = 14'd9216; wr_data[63:32] = 32'h1234_5678;
        tick("oob wr", 2'b10, 2'b00, 1'b0, 32'h0);
        wr_req = 2'b00;
        #1;
        check("err_oob set", 64'(err_oob), 64'(1));
        rd_req = 2'b10; rd_addr[AW +: AW] = 14'd9300;
        tick("oob rd", 2'b00, 2'b10, 1'b0, 32'h0);
        rd_req = 2'b00;
        tick("idle", 2'b00, 2'b00, 1'b0, 32'h0);
        tick("idle", 2'b00, 2'b00, 1'b0, 32'h0);
        check("err_oob sticky", 64'(err_oob), 64'(1));

        // Reset arriving right after the edge that would launch a read return, lock held.
        wr_req = 2'b10; wr_lock = 2'b10; wr_addr[AW +: AW] = 14'd20; wr_data[63:32] = 32'h77;
        rd_req = 2'b01; rd_addr[0 +: AW] = 14'd10;
        #1;
        check("pre-rst wr_gnt", 64'(wr_gnt), 64'(2'b10));
        check("pre-rst rd_gnt", 64'(rd_gnt), 64'(2'b01));
        @(posedge clk);
        #1;
        rst_n  = 1'b0;
        wr_req = 2'b11;
        rd_req = 2'b11;
        @(negedge clk);
        #1;
        check("rst wr_gnt", 64'(wr_gnt), 64'(0));
        check("rst rd_gnt", 64'(rd_gnt), 64'(0));
        check("rst ram_we", 64'(ram_we), 64'(0));
        check("rst rd_valid", 64'(rd_valid), 64'(0));
        check("rst err_oob", 64'(err_oob), 64'(0));
        check("rst rd_data", 64'(rd_data), 64'(0));
        check("rst ram_addr_w", 64'(ram_addr_w), 64'(0));
        check("rst ram_addr_r", 64'(ram_addr_r), 64'(0));
        check("rst ram_din", 64'(ram_din), 64'(0));
        @(negedge clk);
        rst_n = 1'b1;
        wr_addr[0 +: AW] = 14'd30; wr_data[31:0] = 32'h55;
        rd_req = 2'b01;
        #1;
        check("post-rst rd_valid", 64'(rd_valid), 64'(0));
        tick("post-rst", 2'b01, 2'b01, 1'b1, 32'hDEAD_BEEF);

        // Pointer must not move across idle cycles.
        idle_inputs();
        tick("idle", 2'b00, 2'b00, 1'b0, 32'h0);
        tick("idle", 2'b00, 2'b00, 1'b0, 32'h0);
        wr_req = 2'b11;
        tick("ptr hold", 2'b10, 2'b00, 1'b1, 32'h0);
        idle_inputs();

        repeat (3) @(negedge clk);
        check("sb drained", 64'(sb.size()), 64'(0));
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/tensor_ram_arbiter.md
# tensor_ram_arbiter

Shares the single write port and single read port of one `tensor_ram` instance (32-bit words, 4 × 8-bit pixels) among several accelerator requesters, e.g. the input loader, the sliding-window fetcher and the output writeback unit. Read and write ports are arbitrated independently with round-robin fairness and an optional lock for streaming bursts. The block tracks the RAM's one-cycle read latency and returns each read word to the requester that issued it. It also catches out-of-range addresses. It sits directly between the requesters and the RAM ports; it holds no tensor data itself.

## Interface
- `NUM_RD`, 2: number of read requesters (≥1).
- `NUM_WR`, 2: number of write requesters (≥1).
- `D_WIDTH`, 32: RAM word width.
- `DEPTH`, 96*96: RAM depth in words; `AW = $clog2(DEPTH)`.

One clock; reset is asynchronous and active-low.

- `clk`  in  1  clock
- `rst_n`  in  1  async active-low reset
- `wr_req`  in  NUM_WR  per-requester write request
- `wr_lock`  in  NUM_WR  holder keeps the write port on the next cycle
- `wr_addr`  in  NUM_WR×AW  packed write addresses
- `wr_data`  in  NUM_WR×D_WIDTH  packed write data
- `wr_gnt`  out  NUM_WR  one-hot write grant (combinational)
- `rd_req`  in  NUM_RD  per-requester read request
- `rd_lock`  in  NUM_RD  holder keeps the read port on the next cycle
- `rd_addr`  in  NUM_RD×AW  packed read addresses
- `rd_gnt`  out  NUM_RD  one-hot read grant (combinational)
- `rd_valid`  out  NUM_RD  one-hot; data for the requester granted in the previous cycle
- `rd_data`  out  D_WIDTH  shared read-return data, qualified by `rd_valid`
- `ram_we`  out  1  to `tensor_ram.we`
- `ram_addr_w`  out  AW  to `tensor_ram.addr_w`
- `ram_din`  out  D_WIDTH  to `tensor_ram.din`
- `ram_addr_r`  out  AW  to `tensor_ram.addr_r`
- `ram_dout`  in  D_WIDTH  from `tensor_ram.dout`
- `err_oob`  out  1  sticky flag: an address ≥ DEPTH was granted

## Operation
- **Write arbitration**
  - Round-robin search starts at `wr_ptr`. The first requester with `wr_req` set gets `wr_gnt`.
  - On a grant, `wr_ptr` is set to (granted index + 1) mod NUM_WR.
  - Lock: if the granted requester has `wr_lock`=1 in that cycle, the block records an owner. On the next cycle the owner wins whenever its `wr_req`=1, regardless of `wr_ptr`.
  - The lock releases when the owner drops `wr_req` or `wr_lock`. The pointer then advances past the owner.
- **Write datapath**
  - `ram_we` = any grant AND the granted address < DEPTH.
  - `ram_addr_w` and `ram_din` are muxed from the granted requester. They are 0 when there is no grant.
- **Read arbitration**: identical scheme, using `rd_ptr`, `rd_lock` and the read owner.
- **Read datapath**
  - `ram_addr_r` is muxed from the granted read requester. It holds its last value when there is no grant.
  - Registered tracking: `rd_valid_q` <= `rd_gnt`, and `oob_q` <= (granted address ≥ DEPTH).
  - `rd_data` = `ram_dout`, or 0 if `oob_q` is set.
  - Read-during-write to the same address returns the new data. This forwarding is provided by the RAM; the arbiter adds nothing.
- **Out-of-range addresses**
  - An out-of-range read or write is still granted, so the requester does not stall.
  - The write is suppressed; the read returns 0.
  - `err_oob` is set and stays set until reset.
- Read and write arbitration are fully independent. One read and one write may be granted in the same cycle.

## Timing
- Grants are combinational from `*_req`, the pointers and the lock owners in the same cycle. Requesters must hold `req`, `addr` and `data` stable until they see `gnt`.
- A write is committed at the clock edge that ends the grant cycle.
- Read latency is exactly 1: grant in cycle N gives `rd_valid` and `rd_data` in cycle N+1.
- Throughput is one read and one write per cycle. Back-to-back grants to different requesters give back-to-back `rd_valid` to the matching requesters.
- While `rst_n`=0, all outputs are forced as follows: `wr_gnt`=0, `rd_gnt`=0, `ram_we`=0, `rd_valid`=0, `err_oob`=0, `rd_data`=0, `ram_addr_w`=0, `ram_addr_r`=0, `ram_din`=0.
- Reset also clears `wr_ptr`, `rd_ptr` and the lock owners to 0 / none.
- Reset asserted mid-operation:
  - A pending read return is dropped (`rd_valid`=0).
  - Locks are released.
  - After deassertion, arbitration restarts at index 0.
- Pointer behaviour at the boundaries:
  - The pointer wraps from NUM-1 to 0.
  - With a single requester, that requester is granted every cycle it requests.
  - Pointers do not move on cycles with no request.

## Test plan
- **Round-robin writes.** Both write requesters request continuously at addrs 5 and 6, from reset.
  - Grants alternate 0,1,0,1.
  - `ram_we`=1 every cycle.
  - Reading addrs 5 and 6 afterwards returns the last values written.
- **Read return routing.** Reader 0 reads addr 10 (holds 0xDEADBEEF) in cycle N; reader 1 reads addr 11 (0x01020304) in cycle N+1.
  - Cycle N+1: `rd_valid`=01, `rd_data`=0xDEADBEEF.
  - Cycle N+2: `rd_valid`=10, `rd_data`=0x01020304.
- **Lock.** Reader 1 holds `rd_req`=`rd_lock`=1 for 4 cycles while reader 0 also requests.
  - Reader 1 is granted 4 consecutive times.
  - Reader 0 is granted in the cycle after reader 1 drops `rd_lock`.
- **Simultaneous read and write.** Write 0xA5A5A5A5 to addr 100 and read addr 100 in the same cycle.
  - Next cycle: `rd_data`=0xA5A5A5A5.
- **Out-of-range.** Write to addr 9216 with DEPTH=9216, then read addr 9300.
  - Both are granted; `ram_we`=0.
  - `rd_data`=0 with `rd_valid` asserted.
  - `err_oob`=1 and stays set until `rst_n` is pulsed.
- **Reset mid-burst.** Assert `rst_n`=0 one cycle after a read grant, with a write lock held.
  - `rd_valid` stays 0.
  - After release, the first contending grant goes to index 0 and the lock is not honoured.
